gray_count_decoder: RTL and testbench
=====================================

// Module: gray_count_decoder
// PURPOSE
//  Receiving end of a free-running Gray-coded count (e.g. a Gray counter running in a foreign
//  clock domain). Synchronises the Gray word into CLK and decodes it to binary. Extends the
//  count to a wider monotonic binary counter by tracking wrap-around. Flags any sample-to-sample
//  change other than 0 or +1 as a step error. Sits in the consumer domain of timestamp and
//  pointer crossings.
// PARAMETERS
//  P_WIDTH        4   width of Gray input and decoded binary count (>=2)
//  P_EXT_WIDTH    16  width of extended count (>= P_WIDTH)
//  P_SYNC_STAGES  2   synchroniser flops on GRAY_IN (>=2)
// PORTS
//  CLK        in   1            consumer clock; all logic on rising edge
//  RST_N      in   1            asynchronous, active-low reset
//  GRAY_IN    in   P_WIDTH      Gray count from source domain (unsynchronised)
//  CLEAR      in   1            synchronous restart of tracking (priority over tracking)
//  BIN_COUNT  out  P_WIDTH      decoded binary of synchronised GRAY_IN
//  EXT_COUNT  out  P_EXT_WIDTH  extended count; low P_WIDTH bits track BIN_COUNT
//  VALID      out  1            EXT_COUNT holds a tracked value
//  STEP_ERR   out  1            one-cycle pulse: illegal step observed
//  ERR_COUNT  out  8            saturating count of STEP_ERR pulses
// BEHAVIOUR
//  - Reset (RST_N=0, async): sync chain, bin_q, prev_bin, EXT_COUNT, ERR_COUNT = 0;
//    VALID=0, STEP_ERR=0; FSM=FILL, fill counter=0. Outputs go 0 without a clock edge.
//  - Pipeline: GRAY_IN -> P_SYNC_STAGES flops -> bin_q <= gray2bin(last sync stage).
//    BIN_COUNT = bin_q. GRAY_IN stable before edge k appears on BIN_COUNT after edge
//    k+P_SYNC_STAGES; EXT_COUNT/STEP_ERR update one edge later.
//  - gray2bin: b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
//  - FSM FILL: count P_SYNC_STAGES+1 edges to flush pipeline; VALID=0, no errors -> PRIME.
//  - FSM PRIME: one edge: EXT_COUNT <= {0, bin_q}, prev_bin <= bin_q, VALID <= 1 -> TRACK.
//    No STEP_ERR on baseline load.
//  - FSM TRACK (each edge): delta = (bin_q - prev_bin) mod 2^P_WIDTH; prev_bin <= bin_q.
//      delta==0: hold EXT_COUNT.
//      delta==1: EXT_COUNT <= EXT_COUNT+1 (wraps mod 2^P_EXT_WIDTH). Covers the all-ones ->
//        0 wrap of bin_q, which carries into the upper bits.
//      other:    STEP_ERR=1 for one cycle. EXT_COUNT[P_WIDTH-1:0] <= bin_q, upper bits held.
//        ERR_COUNT += 1, saturating at 255.
//  - CLEAR=1 at an edge (any state): EXT_COUNT=0, ERR_COUNT=0, VALID=0, STEP_ERR=0, FSM=FILL,
//    fill counter=0. Sync chain and bin_q keep sampling. CLEAR held: remain in FILL with the
//    fill counter at 0.
//  - P_EXT_WIDTH==P_WIDTH: EXT_COUNT equals bin_q while no errors occur.
//  - CLK must be fast enough to see every source code. A multi-step skip is an error, never
//    interpolated.
// STRUCTURE
//  - gray_pkg: functions gray2bin()/bin2gray(); typedef fsm_t {FILL, PRIME, TRACK};
//    localparam ERR_CNT_W=8.
//  - Sub-module gray_sync_chain (P_WIDTH, P_SYNC_STAGES; CLK, RST_N, D, Q): per-bit flop chain
//    with async active-low reset. Top holds decode, FSM, tracking and error logic.
// TESTING (P_WIDTH=4, P_EXT_WIDTH=8, P_SYNC_STAGES=2)
//  1 Release RST_N, GRAY_IN=4'b0000 held -> VALID rises after 4th edge, EXT_COUNT=8'h00,
//    STEP_ERR never 1.
//  2 Gray 0000,0001,0011,0010,0110, each held 3 cycles -> BIN_COUNT 0,1,2,3,4 (3-edge latency),
//    EXT_COUNT 00..04, no STEP_ERR.
//  3 Walk to gray 1000 (bin 15, EXT 8'h0F), then 0000 -> BIN_COUNT=0, EXT_COUNT=8'h10,
//    no STEP_ERR.
//  4 In TRACK, gray 0001 -> 0110 (bin 1 -> 4) -> one STEP_ERR pulse, EXT_COUNT[3:0]=4,
//    ERR_COUNT=1. Repeat 300 jumps -> ERR_COUNT stays 255.
//  5 EXT_COUNT=8'h23, pulse CLEAR -> next edge EXT_COUNT=0, VALID=0, ERR_COUNT=0. VALID returns
//    after 4 edges with EXT low nibble = current bin, no STEP_ERR.
//  6 Assert RST_N mid-TRACK between clock edges -> all outputs 0 immediately. Release ->
//    sequence of test 1 repeats.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and Gray-code helpers for the Gray count receiver.
package gray_pkg;

    // Widest Gray word the helpers handle; callers zero-extend narrower words.
    localparam int unsigned GRAY_MAX_W = 32;
    localparam int unsigned ERR_CNT_W  = 8;

    typedef enum logic [1:0] {
        FILL,
        PRIME,
        TRACK
    } fsm_t;

    // Each binary bit is the XOR of all Gray bits at or above it.
    // Zero-extended upper bits leave the result unchanged.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Per-bit flop chain bringing a Gray word into the CLK domain.
// Only one bit changes per source step, so per-bit synchronisation is safe.
module gray_sync_chain #(
    parameter int unsigned P_WIDTH       = 4,
    parameter int unsigned P_SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [P_WIDTH-1:0] D,
    output logic [P_WIDTH-1:0] Q
);

    logic [P_WIDTH-1:0] stage_q [P_SYNC_STAGES];

    // Shift the incoming word through the synchroniser stages.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < P_SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= D;
            for (int i = 1; i < P_SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign Q = stage_q[P_SYNC_STAGES-1];

endmodule

// File: rtl/gray_count_decoder.sv
// Receives a free-running Gray count, decodes it to binary, extends it to a wider
// monotonic counter and flags any sample-to-sample change other than 0 or +1.
module gray_count_decoder
    import gray_pkg::*;
#(
    parameter int unsigned P_WIDTH       = 4,
    parameter int unsigned P_EXT_WIDTH   = 16,
    parameter int unsigned P_SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [P_WIDTH-1:0]     GRAY_IN,
    input  logic                   CLEAR,
    output logic [P_WIDTH-1:0]     BIN_COUNT,
    output logic [P_EXT_WIDTH-1:0] EXT_COUNT,
    output logic                   VALID,
    output logic                   STEP_ERR,
    output logic [ERR_CNT_W-1:0]   ERR_COUNT
);

    localparam int unsigned FILL_W = $clog2(P_SYNC_STAGES + 1) + 1;
    localparam logic [P_EXT_WIDTH-1:0] LOW_MASK = P_EXT_WIDTH'({P_WIDTH{1'b1}});

    logic [P_WIDTH-1:0]     sync_q;
    logic [P_WIDTH-1:0]     bin_q;
    logic [P_WIDTH-1:0]     prev_q, prev_d;
    logic [P_WIDTH-1:0]     delta;
    logic [P_EXT_WIDTH-1:0] ext_q, ext_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   valid_q, valid_d;
    logic                   step_err_q, step_err_d;
    fsm_t                   state_q, state_d;

    gray_sync_chain #(
        .P_WIDTH       (P_WIDTH),
        .P_SYNC_STAGES (P_SYNC_STAGES)
    ) u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D     (GRAY_IN),
        .Q     (sync_q)
    );

    // Decode the synchronised Gray word; keeps sampling regardless of CLEAR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bin_q <= '0;
        end else begin
            bin_q <= P_WIDTH'(gray2bin(GRAY_MAX_W'(sync_q)));
        end
    end

    // Tracking FSM and counter state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= FILL;
            fill_q     <= '0;
            prev_q     <= '0;
            ext_q      <= '0;
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            prev_q     <= prev_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Next-state: flush pipeline, load baseline, then follow +1 steps and flag the rest.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        prev_d     = prev_q;
        ext_d      = ext_q;
        valid_d    = valid_q;
        step_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        delta      = bin_q - prev_q;

        if (CLEAR) begin
            state_d   = FILL;
            fill_d    = '0;
            ext_d     = '0;
            valid_d   = 1'b0;
            err_cnt_d = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    valid_d = 1'b0;
                    if (fill_q == FILL_W'(P_SYNC_STAGES)) begin
                        state_d = PRIME;
                        fill_d  = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                PRIME: begin
                    ext_d   = P_EXT_WIDTH'(bin_q);
                    prev_d  = bin_q;
                    valid_d = 1'b1;
                    state_d = TRACK;
                end
                TRACK: begin
                    prev_d = bin_q;
                    if (delta == P_WIDTH'(1)) begin
                        // Includes all-ones -> 0, carrying into the upper bits.
                        ext_d = ext_q + P_EXT_WIDTH'(1);
                    end else if (delta != '0) begin
                        // Resynchronise the low bits; upper bits are not guessed at.
                        step_err_d = 1'b1;
                        ext_d      = (ext_q & ~LOW_MASK) | P_EXT_WIDTH'(bin_q);
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            endcase
        end
    end

    assign BIN_COUNT = bin_q;
    assign EXT_COUNT = ext_q;
    assign VALID     = valid_q;
    assign STEP_ERR  = step_err_q;
    assign ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_gray_count_decoder.sv
// Self-checking bench for gray_count_decoder (P_WIDTH=4, P_EXT_WIDTH=8, P_SYNC_STAGES=2).
module tb_gray_count_decoder;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       CLEAR;
    logic [3:0] GRAY_IN;
    logic [3:0] BIN_COUNT;
    logic [7:0] EXT_COUNT;
    logic       VALID;
    logic       STEP_ERR;
    logic [7:0] ERR_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    gray_count_decoder #(
        .P_WIDTH       (4),
        .P_EXT_WIDTH   (8),
        .P_SYNC_STAGES (2)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .GRAY_IN   (GRAY_IN),
        .CLEAR     (CLEAR),
        .BIN_COUNT (BIN_COUNT),
        .EXT_COUNT (EXT_COUNT),
        .VALID     (VALID),
        .STEP_ERR  (STEP_ERR),
        .ERR_COUNT (ERR_COUNT)
    );

    // Reference model: input history queue plus "edges since restart" age.
    logic [3:0] gq[$];
    int  m_bin, m_since, m_ext, m_last, m_errs;
    bit  m_valid, m_err;

    function automatic int decode(input logic [3:0] g);
        int b = 0;
        for (int i = 0; i < 4; i++) begin
            if (^(g >> i)) b += (1 << i);
        end
        return b;
    endfunction

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        gq = {4'h0, 4'h0};
        m_bin = 0; m_since = 0; m_ext = 0; m_last = 0; m_errs = 0;
        m_valid = 0; m_err = 0;
    endtask

    task automatic model_step();
        int prev, d;
        prev = m_bin;
        m_err = 0;
        if (CLEAR) begin
            m_since = 0; m_ext = 0; m_errs = 0; m_valid = 0;
        end else begin
            if (m_since < 100) m_since++;
            if (m_since == 4) begin
                m_ext = prev; m_last = prev; m_valid = 1;
            end else if (m_since > 4) begin
                d = (prev - m_last) & 15;
                m_last = prev;
                if (d == 1) begin
                    m_ext = (m_ext + 1) & 255;
                end else if (d != 0) begin
                    m_err = 1;
                    m_ext = (m_ext & 'hF0) | prev;
                    if (m_errs < 255) m_errs++;
                end
            end
        end
        gq.push_back(GRAY_IN);
        if (gq.size() > 3) void'(gq.pop_front());
        m_bin = decode(gq[0]);
    endtask

    task automatic compare_all();
        check("bin_count", BIN_COUNT, m_bin);
        check("ext_count", EXT_COUNT, m_ext);
        check("valid", VALID, m_valid);
        check("step_err", STEP_ERR, m_err);
        check("err_count", ERR_COUNT, m_errs);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bin"}, BIN_COUNT, 0);
        check({tag, "_ext"}, EXT_COUNT, 0);
        check({tag, "_valid"}, VALID, 0);
        check({tag, "_step_err"}, STEP_ERR, 0);
        check({tag, "_err_count"}, ERR_COUNT, 0);
    endtask

    typedef struct {
        logic [3:0] gray;
        int         exp_bin;
        int         exp_ext;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] walk [17];
        int src;
        int r;
        bit reached;

        walk = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                 4'b0000};
        for (int i = 0; i < 17; i++) begin
            vecs[i].gray    = walk[i];
            vecs[i].exp_bin = i % 16;
            vecs[i].exp_ext = i;
        end

        // Test 1: reset and fill with a static zero input.
        RST_N = 1'b0; CLEAR = 1'b0; GRAY_IN = 4'b0000;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("t1_valid", VALID, (e >= 4) ? 1 : 0);
            check("t1_step_err", STEP_ERR, 0);
        end

        // Tests 2/3: table walk through all codes and the 15 -> 0 wrap.
        for (int i = 0; i < 17; i++) begin
            GRAY_IN = vecs[i].gray;
            repeat (4) tick();
            check("tbl_bin", BIN_COUNT, vecs[i].exp_bin);
            check("tbl_ext", EXT_COUNT, vecs[i].exp_ext);
            check("tbl_step_err", STEP_ERR, 0);
        end

        // Test 4: one illegal jump 1 -> 4, then saturate the error counter.
        GRAY_IN = 4'b0001;
        repeat (4) tick();
        GRAY_IN = 4'b0110;
        repeat (3) tick();
        check("t4_no_early_err", STEP_ERR, 0);
        tick();
        check("t4_step_err", STEP_ERR, 1);
        check("t4_ext_low", EXT_COUNT & 8'h0F, 4);
        check("t4_ext_high", EXT_COUNT & 8'hF0, 8'h10);
        check("t4_err_count", ERR_COUNT, 1);
        tick();
        check("t4_pulse_end", STEP_ERR, 0);
        for (int i = 0; i < 300; i++) begin
            GRAY_IN = (i % 2 == 0) ? 4'b0001 : 4'b0110;
            tick();
        end
        repeat (4) tick();
        check("t4_err_sat", ERR_COUNT, 255);

        // Randomised walk: holds, +1 steps, arbitrary jumps and occasional CLEAR.
        src = decode(GRAY_IN);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r >= 40 && r < 85) src++;
            else if (r >= 85 && r < 95) src = $urandom_range(0, 15);
            CLEAR = (r >= 97);
            GRAY_IN = to_gray(src);
            tick();
            CLEAR = 1'b0;
        end

        // Test 5: count up to 0x23, then CLEAR and re-acquire.
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        repeat (5) tick();
        reached = (m_ext == 8'h23);
        for (int k = 0; k < 200 && !reached; k++) begin
            src++;
            GRAY_IN = to_gray(src);
            repeat (4) tick();
            reached = (m_ext == 8'h23);
        end
        check("t5_reach", reached, 1);
        check("t5_ext_pre", EXT_COUNT, 8'h23);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        check("t5_ext_clr", EXT_COUNT, 0);
        check("t5_valid_clr", VALID, 0);
        check("t5_errcnt_clr", ERR_COUNT, 0);
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("t5_valid_fill", VALID, 0);
        end
        tick();
        check("t5_valid_back", VALID, 1);
        check("t5_ext_back", EXT_COUNT, src & 15);
        check("t5_step_err", STEP_ERR, 0);

        // Test 6: asynchronous reset between edges while tracking.
        GRAY_IN = to_gray(src + 1);
        repeat (5) tick();
        #2;
        RST_N = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        GRAY_IN = 4'b0000;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("t6_valid", VALID, (e >= 4) ? 1 : 0);
            check("t6_ext", EXT_COUNT, 0);
            check("t6_step_err", STEP_ERR, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
